// File: rtl/vga_tile_fetch.sv
// Tile-map pixel source: fetches 8x8 1bpp tiles from video memory and emits IRGB-decoded
// pixels, with sync/blank re-emitted through an 8-tick delay so everything leaves aligned.
module vga_tile_fetch #(
    parameter int          H_RES        = 640,
    parameter int          V_RES        = 480,
    parameter int          COUNTER_BITS = 10,
    parameter logic [15:0] MAP_BASE     = 16'h0000,
    parameter logic [15:0] PAT_BASE     = 16'h2000
) (
    input  logic                    clk_50MHz,
    input  logic                    clear,
    input  logic                    pix_en,
    input  logic [COUNTER_BITS-1:0] h_count,
    input  logic [COUNTER_BITS-1:0] v_count,
    input  logic                    bright_in,
    input  logic                    h_sync_in,
    input  logic                    v_sync_in,
    output logic                    mem_rd,
    output logic [15:0]             mem_addr,
    input  logic [15:0]             mem_rdata,
    output logic [7:0]              red_out,
    output logic [7:0]              green_out,
    output logic [7:0]              blue_out,
    output logic                    bright_out,
    output logic                    h_sync_out,
    output logic                    v_sync_out,
    output logic                    fetch_late
);

    localparam logic [COUNTER_BITS-1:0] H_LIM = COUNTER_BITS'(H_RES);
    localparam logic [COUNTER_BITS-1:0] V_LIM = COUNTER_BITS'(V_RES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAP_RD,
        S_MAP_WAIT,
        S_PAT_RD,
        S_PAT_WAIT
    } state_t;

    typedef struct packed {
        logic [7:0] pat;
        logic [3:0] fg;
        logic [3:0] bg;
    } tile_word_t;

    // Per-pixel IRGB decode; 4'b1000 is the dark-grey special case.
    function automatic logic [23:0] irgb_to_rgb(input logic [3:0] c);
        logic [7:0] lvl;
        lvl = c[3] ? 8'hFF : 8'hAA;
        if (c == 4'b1000) begin
            return {3{8'h55}};
        end
        return {c[2] ? lvl : 8'h00, c[1] ? lvl : 8'h00, c[0] ? lvl : 8'h00};
    endfunction

    state_t      state_q;
    logic        mem_rd_q;
    logic [15:0] mem_addr_q;
    logic [2:0]  row_q;
    logic [3:0]  fg_q;
    logic [3:0]  bg_q;
    logic        late_q;
    tile_word_t  staging_q;
    tile_word_t  pix_q;

    logic [7:0]  bright_dl_q;
    logic [7:0]  hs_dl_q;
    logic [7:0]  vs_dl_q;
    logic        bright_out_q;
    logic        hs_out_q;
    logic        vs_out_q;
    logic [23:0] rgb_q;

    logic        col_start;
    logic        in_active;
    logic        boundary;
    logic        blank_load;
    logic        shift_load;
    logic        late;
    logic [15:0] ty_w;
    logic [15:0] tx_w;
    logic [15:0] map_addr;
    logic [15:0] pat_addr;
    tile_word_t  load_word;
    logic        cur_bit;
    logic [3:0]  cur_colour;
    logic [23:0] pixel_rgb;

    assign col_start  = (h_count[2:0] == 3'd0);
    assign in_active  = (h_count < H_LIM) && (v_count < V_LIM);
    assign boundary   = pix_en && col_start && in_active;
    assign blank_load = pix_en && col_start && !in_active;
    assign shift_load = boundary || blank_load;
    assign late       = boundary && (state_q != S_IDLE);

    // ty*80 as (ty<<6)+(ty<<4), all in 16-bit wrapping arithmetic.
    assign ty_w     = 16'(v_count[COUNTER_BITS-1:3]);
    assign tx_w     = 16'(h_count[COUNTER_BITS-1:3]);
    assign map_addr = MAP_BASE + (ty_w << 6) + (ty_w << 4) + tx_w;
    assign pat_addr = PAT_BASE + {5'd0, mem_rdata[15:8], 3'd0} + {13'd0, row_q};

    // NOTE: every signal written in an always_comb gets a default first, so no latch is inferred.
    always_comb begin
        load_word  = staging_q;
        cur_bit    = pix_q.pat[7];
        cur_colour = pix_q.bg;
        if (late) begin
            load_word = '0;
        end
        if (shift_load) begin
            cur_bit    = load_word.pat[7];
            cur_colour = cur_bit ? load_word.fg : load_word.bg;
        end else begin
            cur_colour = cur_bit ? pix_q.fg : pix_q.bg;
        end
        pixel_rgb = irgb_to_rgb(cur_colour);
    end

    // A late boundary abandons the fetch in flight and restarts it for the new tile.
    always_ff @(posedge clk_50MHz or negedge clear) begin
        if (!clear) begin
            state_q    <= S_IDLE;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= 16'h0000;
            row_q      <= 3'd0;
            fg_q       <= 4'h0;
            bg_q       <= 4'h0;
            late_q     <= 1'b0;
            staging_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            if (shift_load) begin
                staging_q <= '0;
            end
            if (boundary) begin
                state_q    <= S_MAP_RD;
                mem_rd_q   <= 1'b1;
                mem_addr_q <= map_addr;
                row_q      <= v_count[2:0];
                if (late) begin
                    late_q <= 1'b1;
                end
            end else begin
                case (state_q)
                    S_IDLE: begin
                        mem_rd_q <= 1'b0;
                    end
                    S_MAP_RD: begin
                        mem_rd_q <= 1'b0;
                        state_q  <= S_MAP_WAIT;
                    end
                    S_MAP_WAIT: begin
                        fg_q       <= mem_rdata[7:4];
                        bg_q       <= mem_rdata[3:0];
                        mem_rd_q   <= 1'b1;
                        mem_addr_q <= pat_addr;
                        state_q    <= S_PAT_RD;
                    end
                    S_PAT_RD: begin
                        mem_rd_q <= 1'b0;
                        state_q  <= S_PAT_WAIT;
                    end
                    S_PAT_WAIT: begin
                        staging_q <= '{pat: mem_rdata[7:0], fg: fg_q, bg: bg_q};
                        state_q   <= S_IDLE;
                    end
                    default: begin
                        mem_rd_q <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Delay line plus output register: outputs after tick n reflect the inputs of tick n-8.
    always_ff @(posedge clk_50MHz or negedge clear) begin
        if (!clear) begin
            bright_dl_q  <= 8'h00;
            hs_dl_q      <= 8'hFF;
            vs_dl_q      <= 8'hFF;
            bright_out_q <= 1'b0;
            hs_out_q     <= 1'b1;
            vs_out_q     <= 1'b1;
            rgb_q        <= 24'h000000;
            pix_q        <= '0;
        end else if (pix_en) begin
            bright_dl_q  <= {bright_dl_q[6:0], bright_in};
            hs_dl_q      <= {hs_dl_q[6:0], h_sync_in};
            vs_dl_q      <= {vs_dl_q[6:0], v_sync_in};
            bright_out_q <= bright_dl_q[7];
            hs_out_q     <= hs_dl_q[7];
            vs_out_q     <= vs_dl_q[7];
            rgb_q        <= bright_dl_q[7] ? pixel_rgb : 24'h000000;
            // The first blank boundary still drains the last tile, then staging reads as zero.
            if (shift_load) begin
                pix_q <= '{pat: {load_word.pat[6:0], 1'b0}, fg: load_word.fg, bg: load_word.bg};
            end else begin
                pix_q.pat <= {pix_q.pat[6:0], 1'b0};
            end
        end
    end

    assign mem_rd     = mem_rd_q;
    assign mem_addr   = mem_addr_q;
    assign red_out    = rgb_q[23:16];
    assign green_out  = rgb_q[15:8];
    assign blue_out   = rgb_q[7:0];
    assign bright_out = bright_out_q;
    assign h_sync_out = hs_out_q;
    assign v_sync_out = vs_out_q;
    assign fetch_late = late_q;

endmodule

// File: tb/tb_vga_tile_fetch.sv
// Directed bench for vga_tile_fetch: a small video-memory responder plus per-feature tasks
// with hand-computed expectations.
module tb_vga_tile_fetch;

    logic        clk_50MHz = 1'b0;
    logic        clear     = 1'b0;
    logic        pix_en    = 1'b0;
    logic [9:0]  h_count   = 10'd0;
    logic [9:0]  v_count   = 10'd0;
    logic        bright_in = 1'b0;
    logic        h_sync_in = 1'b1;
    logic        v_sync_in = 1'b1;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata = 16'h0000;
    logic [7:0]  red_out, green_out, blue_out;
    logic        bright_out, h_sync_out, v_sync_out, fetch_late;

    int checks = 0;
    int passed = 0;

    logic [15:0] mem_aa [int];
    logic [15:0] rd_log [$];

    // Hand-derived IRGB table: index = {I,R,G,B}, value = {R,G,B}.
    logic [23:0] colour_lut [16] = '{
        24'h000000, 24'h0000AA, 24'h00AA00, 24'h00AAAA,
        24'hAA0000, 24'hAA00AA, 24'hAAAA00, 24'hAAAAAA,
        24'h555555, 24'h0000FF, 24'h00FF00, 24'h00FFFF,
        24'hFF0000, 24'hFF00FF, 24'hFFFF00, 24'hFFFFFF
    };

    vga_tile_fetch dut (
        .clk_50MHz  (clk_50MHz),
        .clear      (clear),
        .pix_en     (pix_en),
        .h_count    (h_count),
        .v_count    (v_count),
        .bright_in  (bright_in),
        .h_sync_in  (h_sync_in),
        .v_sync_in  (v_sync_in),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .red_out    (red_out),
        .green_out  (green_out),
        .blue_out   (blue_out),
        .bright_out (bright_out),
        .h_sync_out (h_sync_out),
        .v_sync_out (v_sync_out),
        .fetch_late (fetch_late)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (mem_aa.exists(int'(a))) return mem_aa[int'(a)];
        return 16'h0000;
    endfunction

    always @(posedge clk_50MHz) begin
        if (mem_rd) begin
            mem_rdata <= mem_word(mem_addr);
            rd_log.push_back(mem_addr);
        end
    end

    function automatic logic [23:0] model_rgb(input int h, input int v);
        logic [15:0] m;
        logic [15:0] p;
        logic [3:0]  c;
        m = mem_word(16'((v / 8) * 80 + h / 8));
        p = mem_word(16'(32'h2000 + int'(m[15:8]) * 8 + v % 8));
        c = p[7 - h % 8] ? m[7:4] : m[3:0];
        return colour_lut[c];
    endfunction

    task automatic tick(input logic [9:0] h, input logic [9:0] v,
                        input logic b, input logic hs, input logic vs);
        @(negedge clk_50MHz);
        h_count = h; v_count = v; bright_in = b; h_sync_in = hs; v_sync_in = vs;
        pix_en = 1'b1;
        @(negedge clk_50MHz);
        pix_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_50MHz);
    endtask

    task automatic test_reset;
        logic [46:0] got;
        clear = 1'b0;
        for (int n = 0; n < 40; n++) begin
            tick(10'(n), 10'd0, n[0], n[1], n[2]);
            got = {red_out, green_out, blue_out, bright_out, h_sync_out, v_sync_out,
                   mem_rd, fetch_late, mem_addr};
            checks++;
            if (got !== {24'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0})
                $display("FAIL reset_hold tick %0d: got %h required %h", n, got,
                         {24'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0});
            else passed++;
        end
        checks++;
        if (rd_log.size() !== 0) $display("FAIL reset_no_reads: got %0d reads required 0", rd_log.size());
        else passed++;
        @(negedge clk_50MHz);
        clear = 1'b1;
        tick(10'd0, 10'd0, 1'b1, 1'b1, 1'b1);
        checks++;
        if (rd_log.size() !== 0) $display("FAIL release_no_early_read: got %0d reads required 0", rd_log.size());
        else passed++;
        checks++;
        if ({mem_rd, mem_addr} !== {1'b1, 16'h0000})
            $display("FAIL release_first_read: got rd=%b addr=%h required rd=1 addr=0000", mem_rd, mem_addr);
        else passed++;
        idle(8);
    endtask

    task automatic test_addressing;
        logic [23:0] exp_px [8] = '{24'hFF0000, 24'h0000AA, 24'hFF0000, 24'h0000AA,
                                    24'h0000AA, 24'hFF0000, 24'h0000AA, 24'hFF0000};
        rd_log.delete();
        for (int h = 8; h < 16; h++) tick(10'(h), 10'd11, 1'b1, 1'b1, 1'b1);
        for (int j = 0; j < 8; j++) begin
            tick(10'(16 + j), 10'd11, 1'b1, 1'b1, 1'b1);
            checks++;
            if ({red_out, green_out, blue_out} !== exp_px[j])
                $display("FAIL addr_pixel %0d: got %h required %h", j, {red_out, green_out, blue_out}, exp_px[j]);
            else passed++;
        end
        checks++;
        if (rd_log.size() < 2 || rd_log[0] !== 16'h0051)
            $display("FAIL map_addr: got %h (reads %0d) required 0051", rd_log.size() > 0 ? rd_log[0] : 16'hxxxx, rd_log.size());
        else passed++;
        checks++;
        if (rd_log.size() < 2 || rd_log[1] !== 16'h202B)
            $display("FAIL pat_addr: got %h (reads %0d) required 202b", rd_log.size() > 1 ? rd_log[1] : 16'hxxxx, rd_log.size());
        else passed++;
        checks++;
        if (fetch_late !== 1'b0) $display("FAIL addr_no_late: got %b required 0", fetch_late);
        else passed++;
        idle(8);
    endtask

    task automatic test_alignment;
        logic [39:0] bp, hp, vp;
        logic [23:0] exp_rgb;
        bp = 40'hF7_FF3C_E7BD;
        hp = 40'hFF_F00F_C3FF;
        vp = 40'h3F_FFFF_0FF1;
        for (int n = 0; n < 40; n++) begin
            tick(10'(n), 10'd11, bp[n], hp[n], vp[n]);
            if (n >= 8) begin
                checks++;
                if ({bright_out, h_sync_out, v_sync_out} !== {bp[n-8], hp[n-8], vp[n-8]})
                    $display("FAIL align_sync tick %0d: got %b required %b", n,
                             {bright_out, h_sync_out, v_sync_out}, {bp[n-8], hp[n-8], vp[n-8]});
                else passed++;
                exp_rgb = bp[n-8] ? model_rgb(n - 8, 11) : 24'h000000;
                checks++;
                if ({red_out, green_out, blue_out} !== exp_rgb)
                    $display("FAIL align_rgb tick %0d: got %h required %h", n, {red_out, green_out, blue_out}, exp_rgb);
                else passed++;
            end
        end
        idle(8);
    endtask

    task automatic test_colour_table;
        for (int n = 0; n < 136; n++) begin
            tick(10'(n), 10'd16, 1'b1, 1'b1, 1'b1);
            if (n >= 8 && n % 8 == 0) begin
                checks++;
                if ({red_out, green_out, blue_out} !== colour_lut[n / 8 - 1])
                    $display("FAIL colour fg=%h: got %h required %h", n / 8 - 1,
                             {red_out, green_out, blue_out}, colour_lut[n / 8 - 1]);
                else passed++;
            end
        end
        idle(8);
    endtask

    task automatic test_late_fetch;
        for (int n = 1; n <= 8; n++) tick(10'(n), 10'd500, 1'b1, 1'b1, 1'b1);
        idle(4);
        checks++;
        if (fetch_late !== 1'b0) $display("FAIL late_before: got %b required 0", fetch_late);
        else passed++;
        tick(10'd0, 10'd24, 1'b1, 1'b1, 1'b1);
        tick(10'd8, 10'd24, 1'b1, 1'b1, 1'b1);
        checks++;
        if (fetch_late !== 1'b1) $display("FAIL late_set: got %b required 1", fetch_late);
        else passed++;
        checks++;
        if ({red_out, green_out, blue_out} !== 24'h000000)
            $display("FAIL late_black_first: got %h required 000000", {red_out, green_out, blue_out});
        else passed++;
        for (int h = 9; h < 32; h++) begin
            tick(10'(h), 10'd24, 1'b1, 1'b1, 1'b1);
            if (h == 12 || h == 16 || h == 24 || h == 31) begin
                checks++;
                if ({red_out, green_out, blue_out} !== (h == 12 ? 24'h000000 : h == 16 ? 24'hFF0000 : 24'h00FF00))
                    $display("FAIL late_render h=%0d: got %h required %h", h, {red_out, green_out, blue_out},
                             (h == 12 ? 24'h000000 : h == 16 ? 24'hFF0000 : 24'h00FF00));
                else passed++;
            end
        end
        checks++;
        if (fetch_late !== 1'b1) $display("FAIL late_sticky: got %b required 1", fetch_late);
        else passed++;
        idle(4);
    endtask

    task automatic test_reset_mid_fetch;
        logic [46:0] got;
        tick(10'd0, 10'd24, 1'b1, 1'b1, 1'b1);
        checks++;
        if ({red_out, green_out, blue_out} !== 24'hFFFFFF)
            $display("FAIL mid_pre_rgb: got %h required ffffff", {red_out, green_out, blue_out});
        else passed++;
        @(negedge clk_50MHz);
        clear = 1'b0;
        #1;
        got = {red_out, green_out, blue_out, bright_out, h_sync_out, v_sync_out, mem_rd, fetch_late, mem_addr};
        checks++;
        if (got !== {24'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0})
            $display("FAIL mid_reset_outputs: got %h required %h", got, {24'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0});
        else passed++;
        idle(2);
        clear = 1'b1;
        rd_log.delete();
        idle(10);
        checks++;
        if (rd_log.size() !== 0 || mem_rd !== 1'b0)
            $display("FAIL mid_stray_read: got %0d reads rd=%b required 0 reads rd=0", rd_log.size(), mem_rd);
        else passed++;
        tick(10'd0, 10'd24, 1'b1, 1'b1, 1'b1);
        checks++;
        if ({mem_rd, mem_addr} !== {1'b1, 16'h00F0})
            $display("FAIL mid_restart: got rd=%b addr=%h required rd=1 addr=00f0", mem_rd, mem_addr);
        else passed++;
        for (int h = 1; h <= 8; h++) tick(10'(h), 10'd24, 1'b1, 1'b1, 1'b1);
        checks++;
        if (fetch_late !== 1'b0) $display("FAIL mid_idle_after: got late=%b required 0", fetch_late);
        else passed++;
        checks++;
        if ({red_out, green_out, blue_out} !== 24'hFFFFFF)
            $display("FAIL mid_first_tile: got %h required ffffff", {red_out, green_out, blue_out});
        else passed++;
    endtask

    initial begin
        mem_aa[80]     = 16'h05C1;
        mem_aa[81]     = 16'h05C1;
        mem_aa[82]     = 16'h05E9;
        mem_aa[83]     = 16'h0637;
        mem_aa[84]     = 16'h05C1;
        mem_aa[16'h202B] = 16'h00A5;
        mem_aa[16'h2033] = 16'h003C;
        for (int tx = 0; tx < 16; tx++) mem_aa[160 + tx] = {8'h10, 4'(tx), 4'h0};
        mem_aa[16'h2080] = 16'h00FF;
        mem_aa[240]    = 16'h10F0;
        mem_aa[241]    = 16'h10C0;
        mem_aa[242]    = 16'h10A0;
        mem_aa[243]    = 16'h10F0;

        test_reset();
        test_addressing();
        test_alignment();
        test_colour_table();
        test_late_fetch();
        test_reset_mid_fetch();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
